// File: rtl/gpu_raster_pkg.sv
// Shared definitions for the rasterizer-side HiZ scheduling logic: scheduler
// state encodings, default fragment field widths and the requester-ID width helper.
package gpu_raster_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT       = 3'd2,
        ST_CLEAR      = 3'd3,
        ST_CLEAR_WAIT = 3'd4
    } sched_state_t;

    localparam int COORD_W_DEFAULT = 10;
    localparam int DEPTH_W_DEFAULT = 32;

    // ID_W = $clog2(NUM_REQ), kept at least one bit wide for degenerate builds
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/hiz_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or above
// rr_ptr (wrapping) wins; grant is one-hot, grant_idx is its encoded index.
module hiz_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hiz_frag_scheduler.sv
// Shares one HiZ depth-test unit between NUM_REQ fragment streams and sequences
// buffer clears. Define HIZ_SCHED_STATS_EN to add per-requester pass/kill counters.
module hiz_frag_scheduler
    import gpu_raster_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int COORD_W = COORD_W_DEFAULT,
    parameter int DEPTH_W = DEPTH_W_DEFAULT,
    parameter int TIMEOUT = 16
`ifdef HIZ_SCHED_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*COORD_W-1:0]    req_x,
    input  logic [NUM_REQ*COORD_W-1:0]    req_y,
    input  logic [NUM_REQ*DEPTH_W-1:0]    req_z,
    input  logic                          hiz_enable,
    output logic                          dn_valid,
    input  logic                          dn_ready,
    output logic [COORD_W-1:0]            dn_x,
    output logic [COORD_W-1:0]            dn_y,
    output logic [DEPTH_W-1:0]            dn_z,
    output logic                          dn_hiz_enable,
    input  logic                          dn_done,
    input  logic                          dn_pass,
    output logic                          res_valid,
    output logic [id_width(NUM_REQ)-1:0]  res_id,
    output logic                          res_pass,
    input  logic                          clear_req,
    output logic                          clear_ack,
    output logic                          dn_clear,
    input  logic                          dn_clear_done,
    output logic                          busy,
    output logic                          err_timeout
`ifdef HIZ_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0]     stat_pass,
    output logic [NUM_REQ*STAT_W-1:0]     stat_kill
`endif
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    sched_state_t       state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    ptr_next;
    logic [TMR_W-1:0]   timer;
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               clear_go;
    logic               wait_end;

    hiz_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // clear_req is still high during the ack cycle; masking it there stops a second clear
    assign clear_go  = clear_req && !clear_ack;
    assign req_ready = (state == ST_IDLE && !clear_go) ? arb_grant : '0;
    assign busy      = (state != ST_IDLE);
    assign ptr_next  = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
    assign wait_end  = dn_done || (timer == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            gnt_id        <= '0;
            timer         <= '0;
            dn_valid      <= 1'b0;
            dn_x          <= '0;
            dn_y          <= '0;
            dn_z          <= '0;
            dn_hiz_enable <= 1'b0;
            res_valid     <= 1'b0;
            res_id        <= '0;
            res_pass      <= 1'b0;
            clear_ack     <= 1'b0;
            dn_clear      <= 1'b0;
            err_timeout   <= 1'b0;
`ifdef HIZ_SCHED_STATS_EN
            stat_pass     <= '0;
            stat_kill     <= '0;
`endif
        end else begin
            res_valid <= 1'b0;
            clear_ack <= 1'b0;
            dn_clear  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_go) begin
                        dn_clear <= 1'b1;
                        state    <= ST_CLEAR;
                    end else if (|req_valid) begin
                        gnt_id        <= arb_idx;
                        dn_x          <= req_x[arb_idx*COORD_W +: COORD_W];
                        dn_y          <= req_y[arb_idx*COORD_W +: COORD_W];
                        dn_z          <= req_z[arb_idx*DEPTH_W +: DEPTH_W];
                        dn_hiz_enable <= hiz_enable;
                        dn_valid      <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dn_ready) begin
                        dn_valid <= 1'b0;
                        timer    <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // a verdict on the terminal cycle beats the timeout
                    if (wait_end) begin
                        res_valid <= 1'b1;
                        res_id    <= gnt_id;
                        res_pass  <= dn_done && dn_pass;
                        rr_ptr    <= ptr_next;
                        state     <= ST_IDLE;
                        if (!dn_done) err_timeout <= 1'b1;
`ifdef HIZ_SCHED_STATS_EN
                        if (dn_done && dn_pass) begin
                            if (stat_pass[gnt_id*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                                stat_pass[gnt_id*STAT_W +: STAT_W] <= stat_pass[gnt_id*STAT_W +: STAT_W] + 1'b1;
                        end else begin
                            if (stat_kill[gnt_id*STAT_W +: STAT_W] != {STAT_W{1'b1}})
                                stat_kill[gnt_id*STAT_W +: STAT_W] <= stat_kill[gnt_id*STAT_W +: STAT_W] + 1'b1;
                        end
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_CLEAR_WAIT;
                end
                ST_CLEAR_WAIT: begin
                    if (dn_clear_done) begin
                        clear_ack <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hiz_frag_scheduler.sv
// Self-checking bench for hiz_frag_scheduler: the bench plays the rasterizers and
// the HiZ unit, predicting grants and results from a transaction-level model.
module tb_hiz_frag_scheduler;

    localparam int N  = 4;
    localparam int CW = 10;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int SW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_x;
    logic [N*CW-1:0] req_y;
    logic [N*DW-1:0] req_z;
    logic            hiz_enable;
    logic            dn_valid;
    logic            dn_ready;
    logic [CW-1:0]   dn_x;
    logic [CW-1:0]   dn_y;
    logic [DW-1:0]   dn_z;
    logic            dn_hiz_enable;
    logic            dn_done;
    logic            dn_pass;
    logic            res_valid;
    logic [1:0]      res_id;
    logic            res_pass;
    logic            clear_req;
    logic            clear_ack;
    logic            dn_clear;
    logic            dn_clear_done;
    logic            busy;
    logic            err_timeout;
`ifdef HIZ_SCHED_STATS_EN
    logic [N*SW-1:0] stat_pass;
    logic [N*SW-1:0] stat_kill;
`endif

    int assert_count = 0;
    int fail_count   = 0;
    int exp_ptr      = 0;
    bit exp_err      = 1'b0;
    int exp_pass_cnt [N];
    int exp_kill_cnt [N];

    hiz_frag_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_z         (req_z),
        .hiz_enable    (hiz_enable),
        .dn_valid      (dn_valid),
        .dn_ready      (dn_ready),
        .dn_x          (dn_x),
        .dn_y          (dn_y),
        .dn_z          (dn_z),
        .dn_hiz_enable (dn_hiz_enable),
        .dn_done       (dn_done),
        .dn_pass       (dn_pass),
        .res_valid     (res_valid),
        .res_id        (res_id),
        .res_pass      (res_pass),
        .clear_req     (clear_req),
        .clear_ack     (clear_ack),
        .dn_clear      (dn_clear),
        .dn_clear_done (dn_clear_done),
        .busy          (busy),
        .err_timeout   (err_timeout)
`ifdef HIZ_SCHED_STATS_EN
        ,
        .stat_pass     (stat_pass),
        .stat_kill     (stat_kill)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester at or after the pointer, wrapping
    function automatic int pick_winner(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        exp_ptr = 0;
        exp_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_pass_cnt[i] = 0;
            exp_kill_cnt[i] = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_dn_valid"}, 64'(dn_valid), 64'd0);
        checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        checkOutput({tag, "_res_id"}, 64'(res_id), 64'd0);
        checkOutput({tag, "_res_pass"}, 64'(res_pass), 64'd0);
        checkOutput({tag, "_dn_data"}, {dn_z, dn_y, dn_x, dn_hiz_enable}, 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_err"}, 64'(err_timeout), 64'd0);
        checkOutput({tag, "_clear"}, {62'd0, clear_ack, dn_clear}, 64'd0);
    endtask

    // One fragment transaction, entered and left at a negedge with the DUT idle.
    // done_at >= TO means the HiZ unit never answers.
    task automatic applyStimulus(input logic [N-1:0] mask, input int dly, input int done_at,
                                 input bit pass, input bit do_clear, input bit do_abort);
        logic [N-1:0]  onehot;
        logic [CW-1:0] ex, ey;
        logic [DW-1:0] ez;
        logic          eh;
        int            w;
        int            cd;
        bit            timed;

        for (int i = 0; i < N; i++) begin
            req_x[i*CW +: CW] = CW'($urandom);
            req_y[i*CW +: CW] = CW'($urandom);
            req_z[i*DW +: DW] = $urandom;
        end
        hiz_enable = 1'($urandom);
        req_valid  = mask;
        w          = pick_winner(mask, exp_ptr);
        onehot     = N'(1) << w;
        ex = req_x[w*CW +: CW];
        ey = req_y[w*CW +: CW];
        ez = req_z[w*DW +: DW];
        eh = hiz_enable;
        #1;
        checkOutput("req_ready_grant", 64'(req_ready), 64'(onehot));

        @(negedge clk);
        hiz_enable = ~hiz_enable;
        req_valid  = mask & ~onehot;
        for (int d = 0; d <= dly; d++) begin
            checkOutput("dn_valid_issue", 64'(dn_valid), 64'd1);
            checkOutput("dn_data", {dn_z, dn_y, dn_x, dn_hiz_enable}, {ez, ey, ex, eh});
            checkOutput("busy_issue", 64'(busy), 64'd1);
            #1;
            checkOutput("req_ready_issue", 64'(req_ready), 64'd0);
            dn_done       = 1'($urandom);
            dn_clear_done = 1'($urandom);
            dn_ready      = (d == dly);
            if (d < dly) @(negedge clk);
        end

        @(negedge clk);
        dn_ready      = 1'b0;
        dn_done       = 1'b0;
        dn_clear_done = 1'b0;
        req_valid     = '0;
        checkOutput("dn_valid_wait", 64'(dn_valid), 64'd0);
        if (do_clear) clear_req = 1'b1;

        if (do_abort) begin
            repeat (2) begin
                @(negedge clk);
                checkOutput("res_before_abort", 64'(res_valid), 64'd0);
            end
            rst = 1'b0;
            @(negedge clk);
            check_all_zero("abort");
            @(negedge clk);
            rst = 1'b1;
            reset_model();
            @(negedge clk);
            checkOutput("res_after_abort", 64'(res_valid), 64'd0);
            return;
        end

        timed = (done_at >= TO);
        for (int j = 0; j < TO; j++) begin
            checkOutput("res_wait_quiet", 64'(res_valid), 64'd0);
            dn_done = (j == done_at);
            dn_pass = (j == done_at) ? pass : 1'($urandom);
            if (j == done_at || j == TO - 1) break;
            @(negedge clk);
        end
        @(negedge clk);
        dn_done = 1'b0;
        dn_pass = 1'b0;
        exp_err = exp_err | timed;
        checkOutput("res_valid", 64'(res_valid), 64'd1);
        checkOutput("res_id", 64'(res_id), 64'(w));
        checkOutput("res_pass", 64'(res_pass), timed ? 64'd0 : 64'(pass));
        checkOutput("err_timeout", 64'(err_timeout), 64'(exp_err));
        checkOutput("busy_result", 64'(busy), 64'd0);
        exp_ptr = (w + 1) % N;
        if (!timed && pass) exp_pass_cnt[w]++;
        else                exp_kill_cnt[w]++;

        if (do_clear) begin
            req_valid = N'($urandom) | N'(1);
            #1;
            checkOutput("clear_priority", 64'(req_ready), 64'd0);
            @(negedge clk);
            checkOutput("dn_clear_pulse", 64'(dn_clear), 64'd1);
            checkOutput("res_single", 64'(res_valid), 64'd0);
            req_valid     = '0;
            dn_clear_done = 1'b1;
            @(negedge clk);
            dn_clear_done = 1'b0;
            checkOutput("dn_clear_once", 64'(dn_clear), 64'd0);
            cd = $urandom_range(0, 3);
            for (int k = 0; k < cd; k++) begin
                checkOutput("clear_ack_wait", 64'(clear_ack), 64'd0);
                @(negedge clk);
            end
            dn_clear_done = 1'b1;
            @(negedge clk);
            dn_clear_done = 1'b0;
            clear_req     = 1'b0;
            checkOutput("clear_ack", 64'(clear_ack), 64'd1);
            checkOutput("busy_ack", 64'(busy), 64'd0);
            @(negedge clk);
            checkOutput("clear_ack_pulse", 64'(clear_ack), 64'd0);
            checkOutput("dn_clear_idle", 64'(dn_clear), 64'd0);
        end
    endtask

    initial begin
        logic [N-1:0] m;
        rst           = 1'b0;
        req_valid     = '0;
        req_x         = '0;
        req_y         = '0;
        req_z         = '0;
        hiz_enable    = 1'b0;
        dn_ready      = 1'b0;
        dn_done       = 1'b0;
        dn_pass       = 1'b0;
        clear_req     = 1'b0;
        dn_clear_done = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus(4'b0100, 0, 3, 1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(4'b1111, 0, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1, TO + 4, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b0011, 5, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b1111, 0, 2, 1'b1, 1'b1, 1'b0);
        applyStimulus(4'b0110, 0, 5, 1'b1, 1'b0, 1'b1);
        applyStimulus(4'b1111, 0, TO - 1, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'b1000, 2, TO - 2, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            m = N'($urandom);
            if (m == '0) m = N'(1) << $urandom_range(0, N - 1);
            applyStimulus(m, $urandom_range(0, 3), $urandom_range(0, TO + 2),
                          1'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
        end

`ifdef HIZ_SCHED_STATS_EN
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("stat_pass%0d", i), 64'(stat_pass[i*SW +: SW]), 64'(exp_pass_cnt[i]));
            checkOutput($sformatf("stat_kill%0d", i), 64'(stat_kill[i*SW +: SW]), 64'(exp_kill_cnt[i]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
